alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU port and the response channel.
// The arbiter takes the slave side; requesters, ALU and consumer take the master side.
interface alu_arbiter_if #(parameter int N = 32);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_flags, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_flags, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared combinational ALU,
// one operation in flight: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold result).
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   r_state;
    logic         r_prio;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [2:0]   r_op;
    logic         r_id;
    logic [N-1:0] r_rsp_result;
    logic [3:0]   r_rsp_flags;
    logic         r_rsp_err;

    logic         w_idle;
    logic         w_gnt0;
    logic         w_gnt1;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic [2:0]   w_sel_op;
    logic         w_illegal;

    // Grant selection: r_prio=0 favours req0, r_prio=1 favours req1 under contention
    always_comb begin
        w_idle = (r_state == S_IDLE);
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (bus.req0_valid && (!bus.req1_valid || !r_prio)) begin
            w_gnt0 = 1'b1;
        end else if (bus.req1_valid) begin
            w_gnt1 = 1'b1;
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // Operand mux feeding the latch on a handshake
    always_comb begin
        w_sel_a  = bus.req0_a;
        w_sel_b  = bus.req0_b;
        w_sel_op = bus.req0_op;
        if (w_gnt1) begin
            w_sel_a  = bus.req1_a;
            w_sel_b  = bus.req1_b;
            w_sel_op = bus.req1_op;
        end else begin
            w_sel_a  = bus.req0_a;
            w_sel_b  = bus.req0_b;
            w_sel_op = bus.req0_op;
        end
    end

    assign w_illegal = r_op[2] & r_op[1];

    // Ready is combinational so a requester is accepted in the same cycle it presents valid
    assign bus.req0_ready = w_idle & w_gnt0;
    assign bus.req1_ready = w_idle & w_gnt1;

    // ALU inputs always come from the latched operands, so they only move on a new grant
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = !w_idle;

    // FSM, priority and request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_a     <= {N{1'b0}};
            r_b     <= {N{1'b0}};
            r_op    <= 3'd0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_id    <= w_gnt1;
                        r_prio  <= w_gnt0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Response capture at the end of EXEC; illegal opcodes report zeros with the error bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_result <= {N{1'b0}};
            r_rsp_flags  <= 4'b0000;
            r_rsp_err    <= 1'b0;
        end else if (r_state == S_EXEC) begin
            if (w_illegal) begin
                r_rsp_result <= {N{1'b0}};
                r_rsp_flags  <= 4'b0000;
                r_rsp_err    <= 1'b1;
            end else begin
                r_rsp_result <= bus.alu_result;
                r_rsp_flags  <= bus.alu_flags;
                r_rsp_err    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single operations, a cycle-level
// monitor with a scoreboard queue, and hand-written contention/backpressure/reset sequences.
module tb_alu_arbiter;
    localparam int N = 32;

    logic clk;
    logic rst;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [N-1:0] exp_result;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [N-1:0] result;
        logic [3:0]   flags;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    int   rsp_ids[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu_res(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return (b == {N{1'b0}}) ? {N{1'b1}} : a / b;
            3'd4:    return (b == {N{1'b0}}) ? a : a % b;
            3'd5:    return a;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [3:0] alu_flg(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        logic [N-1:0] r;
        r = alu_res(a, b, op);
        if (op >= 3'd6) return 4'hF;
        return {(r == {N{1'b0}}), r[N-1], a[0], b[0]};
    endfunction

    // Stand-in for the shared combinational ALU
    always_comb begin
        bus.alu_result = alu_res(bus.alu_a, bus.alu_b, bus.alu_op);
        bus.alu_flags  = alu_flg(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Cycle-level reference model, sampled on the falling edge
    initial begin : monitor
        logic [1:0]   m_st;
        logic         m_prio;
        logic [N-1:0] m_a;
        logic [N-1:0] m_b;
        logic [2:0]   m_op;
        logic         e0;
        logic         e1;
        exp_t         e;
        m_st = 2'd0; m_prio = 1'b0; m_a = '0; m_b = '0; m_op = 3'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_st = 2'd0; m_prio = 1'b0; m_a = '0; m_b = '0; m_op = 3'd0;
                sb_q.delete();
                check("rst_ready0", bus.req0_ready, 1'b0);
                check("rst_ready1", bus.req1_ready, 1'b0);
                check("rst_rsp_valid", bus.rsp_valid, 1'b0);
                check("rst_rsp_id", bus.rsp_id, 1'b0);
                check("rst_rsp_result", bus.rsp_result, 32'd0);
                check("rst_rsp_flags", bus.rsp_flags, 4'd0);
                check("rst_rsp_err", bus.rsp_err, 1'b0);
                check("rst_busy", bus.busy, 1'b0);
                check("rst_alu_a", bus.alu_a, 32'd0);
                check("rst_alu_b", bus.alu_b, 32'd0);
                check("rst_alu_op", bus.alu_op, 3'd0);
            end else begin
                e0 = (m_st == 2'd0) && bus.req0_valid && (!bus.req1_valid || !m_prio);
                e1 = (m_st == 2'd0) && bus.req1_valid && !e0;
                check("mon_ready0", bus.req0_ready, e0);
                check("mon_ready1", bus.req1_ready, e1);
                check("mon_busy", bus.busy, (m_st != 2'd0));
                check("mon_rsp_valid", bus.rsp_valid, (m_st == 2'd2));
                check("mon_alu_a", bus.alu_a, m_a);
                check("mon_alu_b", bus.alu_b, m_b);
                check("mon_alu_op", bus.alu_op, m_op);
                case (m_st)
                    2'd0: begin
                        if (e0 || e1) begin
                            e.id     = e1;
                            e.a      = e1 ? bus.req1_a : bus.req0_a;
                            e.b      = e1 ? bus.req1_b : bus.req0_b;
                            e.op     = e1 ? bus.req1_op : bus.req0_op;
                            e.err    = (e.op >= 3'd6);
                            e.result = e.err ? '0 : alu_res(e.a, e.b, e.op);
                            e.flags  = e.err ? 4'd0 : alu_flg(e.a, e.b, e.op);
                            sb_q.push_back(e);
                            m_a = e.a; m_b = e.b; m_op = e.op;
                            m_prio = e0;
                            m_st = 2'd1;
                        end
                    end
                    2'd1: m_st = 2'd2;
                    default: begin
                        check("sb_nonempty", (sb_q.size() != 0), 1'b1);
                        if (sb_q.size() != 0) begin
                            check("sb_rsp_id", bus.rsp_id, sb_q[0].id);
                            check("sb_rsp_result", bus.rsp_result, sb_q[0].result);
                            check("sb_rsp_flags", bus.rsp_flags, sb_q[0].flags);
                            check("sb_rsp_err", bus.rsp_err, sb_q[0].err);
                            if (bus.rsp_ready) begin
                                rsp_ids.push_back(int'(sb_q[0].id));
                                void'(sb_q.pop_front());
                                m_st = 2'd0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [2:0] op);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    localparam int NV = 9;
    vec_t tbl [NV];

    initial begin
        tbl[0] = '{1'b0, 32'd7,          32'd5,  3'd0, 32'd12,         1'b0};
        tbl[1] = '{1'b1, 32'd100,        32'd58, 3'd1, 32'd42,         1'b0};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,  3'd0, 32'd0,          1'b0};
        tbl[3] = '{1'b0, 32'd3,          32'd5,  3'd1, 32'hFFFF_FFFE,  1'b0};
        tbl[4] = '{1'b1, 32'd6,          32'd7,  3'd2, 32'd42,         1'b0};
        tbl[5] = '{1'b0, 32'd100,        32'd7,  3'd3, 32'd14,         1'b0};
        tbl[6] = '{1'b1, 32'd100,        32'd7,  3'd4, 32'd2,          1'b0};
        tbl[7] = '{1'b0, 32'h1234_5678,  32'd0,  3'd5, 32'h1234_5678,  1'b0};
        tbl[8] = '{1'b1, 32'd3,          32'd4,  3'd7, 32'd0,          1'b1};

        clk = 1'b0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 3'd0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Single operations: ready in cycle 0, operands on ALU in cycle 1, response in cycle 2
        for (int i = 0; i < NV; i++) begin
            drive_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op);
            #1;
            check("vec_ready", tbl[i].id ? bus.req1_ready : bus.req0_ready, 1'b1);
            tick();
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            check("vec_alu_a", bus.alu_a, tbl[i].a);
            check("vec_alu_op", bus.alu_op, tbl[i].op);
            tick();
            check("vec_rsp_valid", bus.rsp_valid, 1'b1);
            check("vec_rsp_result", bus.rsp_result, tbl[i].exp_result);
            check("vec_rsp_id", bus.rsp_id, tbl[i].id);
            check("vec_rsp_err", bus.rsp_err, tbl[i].exp_err);
            tick();
        end
        check("illegal_flags_cleared", bus.rsp_flags, 4'd0);

        // Contention: both valid every cycle, grants must alternate starting at req0
        rsp_ids.delete();
        drive_req(1'b0, 32'd10, 32'd3, 3'd2);
        drive_req(1'b1, 32'd10, 32'd3, 3'd1);
        repeat (12) tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (2) tick();
        check("cont_count", rsp_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rsp_ids.size()) check("cont_id_seq", rsp_ids[i], i % 2);
        end

        // Backpressure with both requesters waiting; req1 holds priority afterwards
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 32'd1, 32'd2, 3'd0);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        drive_req(1'b0, 32'd9, 32'd9, 3'd0);
        drive_req(1'b1, 32'd20, 32'd4, 3'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_rsp_result", bus.rsp_result, 32'd3);
            check("bp_busy", bus.busy, 1'b1);
            check("bp_ready_both", {bus.req0_ready, bus.req1_ready}, 2'b00);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_no_accept_on_rsp", {bus.req0_ready, bus.req1_ready}, 2'b00);
        tick();
        check("bp_idle_after", bus.busy, 1'b0);
        check("bp_grant_req1", {bus.req0_ready, bus.req1_ready}, 2'b01);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (2) tick();

        // Reset in EXEC after req0 grant (priority moved to req1) must restore req0 priority
        drive_req(1'b0, 32'd50, 32'd60, 3'd0);
        tick();
        bus.req0_valid = 1'b0;
        check("rstx_in_exec", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rstx_busy", bus.busy, 1'b0);
        check("rstx_alu_a", bus.alu_a, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstx_no_rsp", bus.rsp_valid, 1'b0);
        end
        drive_req(1'b0, 32'd11, 32'd22, 3'd0);
        drive_req(1'b1, 32'd5, 32'd5, 3'd0);
        #1;
        check("rstx_first_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        check("rstx_rsp_result", bus.rsp_result, 32'd33);
        tick();

        // Withdrawn request: req1 pulses valid during EXEC only
        rsp_ids.delete();
        drive_req(1'b0, 32'd8, 32'd2, 3'd4);
        tick();
        bus.req0_valid = 1'b0;
        drive_req(1'b1, 32'd77, 32'd1, 3'd0);
        #1;
        check("wd_ready1_exec", bus.req1_ready, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        repeat (2) tick();
        check("wd_only_req0", rsp_ids.size(), 1);
        if (rsp_ids.size() == 1) check("wd_rsp_id", rsp_ids[0], 0);
        drive_req(1'b0, 32'd4, 32'd4, 3'd2);
        drive_req(1'b1, 32'd4, 32'd5, 3'd2);
        #1;
        check("wd_prio_kept", {bus.req0_ready, bus.req1_ready}, 2'b01);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        check("wd_rsp_result", bus.rsp_result, 32'd20);
        repeat (3) tick();

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
